// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and op-class helper for the multi-cycle ALU.
// No logic; imported by alu_mc and alu_muldiv_iter.
// Exports: ALU_* opcode localparams, state_t (ST_IDLE/ST_BUSY/ST_DONE), is_iter(op).
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_MUL   = 4'b1010;
  localparam logic [3:0] ALU_MULHU = 4'b1011;
  localparam logic [3:0] ALU_DIVU  = 4'b1100;
  localparam logic [3:0] ALU_REMU  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ops that go through the radix-2 multiply/divide engine.
  function automatic logic is_iter(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_MULHU) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU engine on a 2*WIDTH accumulator, one radix-2 step per cycle.
// Latency: done pulses WIDTH cycles after start (data independent); result is valid only while done=1.
// Backpressure: none; the caller must take the result in the done cycle and not restart while busy.
// Ports: clk, rst (sync, active high), start/op/a/b (operation capture), done (1-cycle pulse), result.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int SHW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd_q;     // multiplicand for MUL*, divisor for DIV/REM
  logic [SHW-1:0]     cnt_q;
  logic               busy_q;
  logic               mul_q;
  logic               hi_q;       // take upper accumulator half (MULHU, REMU)
  logic               start_mul;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH-1:0]   div_diff;

  assign start_mul = (op == ALU_MUL) || (op == ALU_MULHU);

  always_comb begin
    // Multiply: {hi, lo} with lo holding the remaining multiplier bits; add then shift right.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    // Divide: {rem, quot}; shift left one, trial-subtract divisor from the widened remainder.
    div_trial = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_trial[WIDTH-1:0] - opnd_q;
    acc_next  = '0;
    if (mul_q) begin
      acc_next = {mul_sum, acc_q[WIDTH-1:1]};
    end else if (div_trial >= {1'b0, opnd_q}) begin
      // With a zero divisor this branch is always taken: quotient all ones, remainder = a.
      acc_next = {div_diff, acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  assign done   = busy_q && (cnt_q == '0);
  assign result = hi_q ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      mul_q  <= 1'b0;
      hi_q   <= 1'b0;
    end else if (start) begin
      mul_q  <= start_mul;
      hi_q   <= (op == ALU_MULHU) || (op == ALU_REMU);
      opnd_q <= start_mul ? a : b;
      acc_q  <= {{WIDTH{1'b0}}, (start_mul ? b : a)};
      cnt_q  <= SHW'(WIDTH - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_next;
      cnt_q <= cnt_q - SHW'(1);
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute ALU: simple ops registered in one cycle, MUL/MULHU/DIVU/REMU iterate WIDTH cycles.
// Latency: out_valid from edge E+1 (simple) or E+WIDTH+1 (iterative) after acceptance edge E.
// Backpressure: result/zero held in DONE until out_ready; in_ready only in IDLE, one op in flight.
// Ports: clk, rst (sync, active high), in_valid/in_ready/a/b/alu_ctrl (request),
//        out_valid/out_ready/result/zero (registered response).
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  state_t           state_q;
  state_t           state_d;
  logic             live_q;      // low during reset so in_ready stays low until rst is released
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             accept;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] simple_res;
  logic [SHW-1:0]   shamt;
  logic             iter_done;
  logic [WIDTH-1:0] iter_result;

  assign in_ready  = live_q && (state_q == ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign shamt     = b[SHW-1:0];

  always_comb begin
    simple_res = '0;
    case (alu_ctrl)
      ALU_ADD:  simple_res = a + b;
      ALU_SUB:  simple_res = a - b;
      ALU_AND:  simple_res = a & b;
      ALU_OR:   simple_res = a | b;
      ALU_XOR:  simple_res = a ^ b;
      ALU_SLL:  simple_res = a << shamt;
      ALU_SRL:  simple_res = a >> shamt;
      ALU_SRA:  simple_res = $signed(a) >>> shamt;
      ALU_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: simple_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default:  simple_res = '0;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && is_iter(alu_ctrl)),
    .op     (alu_ctrl),
    .a      (a),
    .b      (b),
    .done   (iter_done),
    .result (iter_result)
  );

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_iter(alu_ctrl)) begin
            state_d = ST_BUSY;
          end else begin
            state_d  = ST_DONE;
            load     = 1'b1;
            load_val = simple_res;
          end
        end
      end
      ST_BUSY: begin
        if (iter_done) begin
          state_d  = ST_DONE;
          load     = 1'b1;
          load_val = iter_result;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      live_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      if (load) begin
        result_q <= load_val;
        zero_q   <= (load_val == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=32 and WIDTH=8 (two instances sharing stimulus).
// sel8 picks which instance the request goes to and which outputs are observed.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        sel8;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_ctrl;
  logic        out_ready;

  logic        in_ready32, out_valid32, zero32;
  logic [31:0] result32;
  logic        in_ready8, out_valid8, zero8;
  logic [7:0]  result8;

  wire         in_valid32 = in_valid & ~sel8;
  wire         in_valid8  = in_valid & sel8;
  wire         in_ready_m  = sel8 ? in_ready8 : in_ready32;
  wire         out_valid_m = sel8 ? out_valid8 : out_valid32;
  wire         zero_m      = sel8 ? zero8 : zero32;
  wire  [31:0] result_m    = sel8 ? {24'h0, result8} : result32;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a), .b(b), .alu_ctrl(alu_ctrl), .out_valid(out_valid32),
    .out_ready(out_ready), .result(result32), .zero(zero32)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a[7:0]), .b(b[7:0]), .alu_ctrl(alu_ctrl), .out_valid(out_valid8),
    .out_ready(out_ready), .result(result8), .zero(zero8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready_m && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_rdy"}, in_ready_m, 1);
  endtask

  // Issue one op, scramble inputs after acceptance, measure latency and check the response.
  task automatic do_op(input bit w8, input logic [3:0] op, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] exp, input string tag);
    int lat;
    int exp_lat;
    bit rdy_bad;
    sel8 = w8;
    exp_lat = (op inside {4'hA, 4'hB, 4'hC, 4'hD}) ? (w8 ? 9 : 33) : 1;
    wait_ready(tag);
    a = va; b = vb; alu_ctrl = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~va; b = ~vb; alu_ctrl = 4'h0;
    lat = 1;
    rdy_bad = 1'b0;
    while (!out_valid_m && lat < 100) begin
      if (in_ready_m) rdy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, result_m, exp);
    chk({tag, "_zero"}, zero_m, (exp == 32'h0));
    if (exp_lat > 1) chk({tag, "_busy_rdy"}, rdy_bad, 0);
  endtask

  // One edge with out_ready=1 completes the transfer; in_ready must then be up.
  task automatic xfer(input string tag);
    @(posedge clk); #1;
    chk({tag, "_xfer_ov"}, out_valid_m, 0);
    chk({tag, "_xfer_rdy"}, in_ready_m, 1);
  endtask

  task automatic op_x(input bit w8, input logic [3:0] op, input logic [31:0] va,
                      input logic [31:0] vb, input logic [31:0] exp, input string tag);
    do_op(w8, op, va, vb, exp, tag);
    xfer(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit stable;
    bit seen;
    rst = 1'b1; in_valid = 1'b0; sel8 = 1'b0; a = '0; b = '0; alu_ctrl = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy32", in_ready32, 0);
    chk("rst_ov32", out_valid32, 0);
    chk("rst_res32", result32, 0);
    chk("rst_zero32", zero32, 1);
    chk("rst_ov8", out_valid8, 0);
    chk("rst_zero8", zero8, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_rel_rdy32", in_ready32, 1);
    chk("rst_rel_rdy8", in_ready8, 1);

    // WIDTH=32 simple ops
    op_x(0, 4'h0, 32'd5, 32'd7, 32'd12, "add");
    op_x(0, 4'h1, 32'd3, 32'd3, 32'd0, "sub_zero");
    op_x(0, 4'h1, 32'd0, 32'd1, 32'hFFFF_FFFF, "sub_wrap");
    op_x(0, 4'h7, 32'h8000_0000, 32'd4, 32'hF800_0000, "sra");
    op_x(0, 4'h8, 32'hFFFF_FFFF, 32'd1, 32'd1, "slt");
    op_x(0, 4'h9, 32'hFFFF_FFFF, 32'd1, 32'd0, "sltu");
    op_x(0, 4'h5, 32'd1, 32'd31, 32'h8000_0000, "sll");
    op_x(0, 4'h6, 32'h8000_0000, 32'd31, 32'd1, "srl");
    op_x(0, 4'h2, 32'hF0F0, 32'hFF00, 32'hF000, "and");
    op_x(0, 4'h3, 32'hF0F0, 32'hFF00, 32'hFFF0, "or");
    op_x(0, 4'h4, 32'hF0F0, 32'hFF00, 32'h0FF0, "xor");
    op_x(0, 4'hE, 32'd5, 32'd7, 32'd0, "op_e");
    // WIDTH=32 iterative ops
    op_x(0, 4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul");
    op_x(0, 4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
    op_x(0, 4'hA, 32'd12345, 32'd1000, 32'd12345000, "mul_dec");
    op_x(0, 4'hC, 32'd100, 32'd7, 32'd14, "divu");
    op_x(0, 4'hD, 32'd100, 32'd7, 32'd2, "remu");
    op_x(0, 4'hC, 32'd9, 32'd0, 32'hFFFF_FFFF, "divu_by0");
    op_x(0, 4'hD, 32'd9, 32'd0, 32'd9, "remu_by0");

    // Backpressure: hold out_ready low in DONE with a competing request pending.
    out_ready = 1'b0;
    do_op(0, 4'h0, 32'h10, 32'h20, 32'h30, "bp");
    in_valid = 1'b1; a = 32'd1; b = 32'd1; alu_ctrl = 4'h0;
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (!out_valid_m || result_m !== 32'h30 || in_ready_m) stable = 1'b0;
    end
    chk("bp_hold", stable, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_xfer_ov", out_valid_m, 0);
    chk("bp_xfer_rdy", in_ready_m, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_ov", out_valid_m, 1);
    chk("bp_next_res", result_m, 32'd2);
    xfer("bp_next");

    // WIDTH=8 directed cases
    op_x(1, 4'h0, 32'hF0, 32'h20, 32'h10, "w8_add_wrap");
    op_x(1, 4'h1, 32'h00, 32'h01, 32'hFF, "w8_sub_wrap");
    op_x(1, 4'h1, 32'h33, 32'h33, 32'h00, "w8_sub_zero");
    op_x(1, 4'h7, 32'h80, 32'h04, 32'hF8, "w8_sra");
    op_x(1, 4'h8, 32'hFF, 32'h01, 32'h01, "w8_slt");
    op_x(1, 4'h9, 32'hFF, 32'h01, 32'h00, "w8_sltu");
    op_x(1, 4'h5, 32'h01, 32'h09, 32'h02, "w8_sll_mask");
    op_x(1, 4'hA, 32'hFF, 32'hFF, 32'h01, "w8_mul");
    op_x(1, 4'hB, 32'hFF, 32'hFF, 32'hFE, "w8_mulhu");
    op_x(1, 4'hC, 32'd100, 32'd7, 32'd14, "w8_divu");
    op_x(1, 4'hD, 32'd100, 32'd7, 32'd2, "w8_remu");
    op_x(1, 4'hC, 32'd9, 32'd0, 32'hFF, "w8_divu_by0");
    op_x(1, 4'hD, 32'd9, 32'd0, 32'd9, "w8_remu_by0");

    // Reset while a WIDTH=32 DIVU is in BUSY (rst sampled at E+10); prior result is nonzero.
    sel8 = 1'b0;
    wait_ready("rst_busy");
    a = 32'd100; b = 32'd7; alu_ctrl = 4'hC; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy_ov", out_valid32, 0);
    chk("rst_busy_res", result32, 0);
    chk("rst_busy_zero", zero32, 1);
    chk("rst_busy_rdy", in_ready32, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy_rdy_rel", in_ready32, 1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid32) seen = 1'b1;
    end
    chk("rst_busy_no_ov", seen, 0);
    chk("rst_busy_res_after", result32, 0);

    // Engine still usable after the abort.
    op_x(0, 4'hC, 32'd100, 32'd7, 32'd14, "post_rst_divu");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU, the successor to the single-cycle execute ALU. It sits in the execute stage of the RISC-V core behind a valid/ready handshake. It keeps the existing ADD/SUB/AND/OR/XOR encodings and adds shifts and compares. It also adds iterative unsigned multiply and divide (MUL, MULHU, DIVU, REMU), whose latency is data-independent. Results and the zero flag are registered and held until the consumer accepts them.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 4 and a power of two.
- `SHW`, default $clog2(WIDTH): shift-amount width (derived, not overridden).
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept a request.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `alu_ctrl`  in  4  opcode, sampled on acceptance.
- `out_valid`  out  1  `result`/`zero` are valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  WIDTH  registered result.
- `zero`  out  1  1 iff `result` == 0, registered together with `result`.

## Operation
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount = b[SHW-1:0].
  - 1000 SLT (signed), 1001 SLTU; result is 1 or 0, zero-extended.
  - 1010 MUL = low WIDTH bits of a×b. 1011 MULHU = high WIDTH bits of unsigned a×b.
  - 1100 DIVU = unsigned a/b. 1101 REMU = unsigned a%b.
  - 1110, 1111: result 0, treated as a simple op.
- Arithmetic is modulo 2^WIDTH. SUB wraps, e.g. 0 − 1 = all ones.
- Divide by zero: DIVU returns all ones, REMU returns `a`. It completes in the normal iterative latency; no exception.
- FSM states:
  - IDLE: `in_ready`=1. On in_valid, simple op → DONE (result computed combinationally and registered); iterative op → BUSY with counter = WIDTH−1.
  - BUSY: one radix-2 step per cycle (shift-add multiply / restoring divide on a 2·WIDTH-bit accumulator). Counter decrements. When counter = 0, the final step is taken, the result is registered and the state moves to DONE.
  - DONE: `out_valid`=1; `result`/`zero` held stable. If out_ready=1 → IDLE.
- `in_ready` = (state == IDLE) only. No request is accepted in BUSY or DONE, even if out_ready=1 in the same cycle.
- Operands and opcode are captured at acceptance; later changes on `a`/`b`/`alu_ctrl` have no effect.

## Timing
- Acceptance at clock edge E means in_valid & in_ready are sampled high at E.
- Simple-op latency: out_valid is high from edge E+1.
- Iterative-op latency: BUSY occupies edges E+1..E+WIDTH; out_valid is high from edge E+WIDTH+1. This is fixed and independent of the data (33 edges for WIDTH=32).
- Result transfer occurs at the first edge with out_valid & out_ready both high. in_ready rises at the following edge.
- Maximum throughput: one simple op per 2 cycles.
- Reset:
  - rst=1 at any edge forces IDLE and clears the counter and accumulator.
  - Output values: in_ready=0 during reset and 1 from the first edge with rst=0; out_valid=0; result=0; zero=1.
  - Reset during BUSY or DONE aborts the operation; no partial result is ever presented.
- in_valid while not ready is ignored. The requester must hold the request until accepted.

## Structure
- `alu_pkg`:
  - opcode localparams (ALU_ADD … ALU_REMU) shared with the decoder;
  - FSM state encoding (ST_IDLE, ST_BUSY, ST_DONE);
  - `is_iter(op)` helper.
- Sub-module `alu_muldiv_iter`: owns the 2·WIDTH accumulator, the counter and step logic for MUL/MULHU/DIVU/REMU. It has a start/done pulse interface.
- The top level holds the FSM, the simple-op datapath, and the output/zero registers.

## Test plan
- Reset then ADD (WIDTH=32): a=5, b=7, op 0000, out_ready=1 → out_valid at E+1, result=12, zero=0; then in_ready=1.
- SUB wrap and zero flag: 3−3 → result 0, zero=1. 0−1 → 0xFFFFFFFF. SRA 0x80000000 by 4 → 0xF8000000. SLT 0xFFFFFFFF,1 → 1; SLTU same → 0.
- Multiply: MUL and MULHU of 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001 and 0xFFFFFFFE. out_valid rises exactly 33 edges after acceptance; in_ready=0 throughout.
- Divide: DIVU 100/7 → 14, REMU → 2. Divide by zero: DIVU 9/0 → 0xFFFFFFFF, REMU 9/0 → 9, both at the same 33-edge latency.
- Backpressure: hold out_ready=0 for 5 cycles after DONE → result stable, in_valid ignored. Raise out_ready → transfer in one cycle, then the next request is accepted.
- Reset mid-BUSY (DIVU, rst at edge E+10) → out_valid never asserts, result=0, zero=1, in_ready=1 after reset is released. Repeat the directed cases at WIDTH=8.
